// File: rtl/respuesta_cero_stream.sv
// -----------------------------------------------------------------------------
// respuesta_cero_stream
//
// Registered, handshaked zero detector. Every accepted tuple produces one
// response {Respuesta, Racha} in arrival order:
//   Respuesta : 1 when the tuple was all zeros
//   Racha     : length of the current run of consecutive zero tuples,
//               counting this tuple, saturating at 2**RACHA_W-1
// A 2-entry response buffer absorbs back-pressure from the consumer.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holding valid keeps its data
// stable until that edge. tupla_listo is decoded from the registered buffer
// occupancy only, so there is no combinational path from resp_listo to
// tupla_listo; a slot freed by a pop is offered on the following cycle.
//
// Optional feature (macro IGUALCERO_TOTAL_EN): adds a 16-bit wrapping
// counter total_ceros of accepted zero tuples, cleared by limpiar.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_L       in   asynchronous active-low reset
//   Tupla         in   [ANCHO-1:0] tuple under test
//   tupla_valida  in   Tupla is valid
//   tupla_listo   out  block can accept a tuple (buffer not full)
//   limpiar       in   synchronous clear of the run counter (and total)
//   resp_valida   out  buffer head holds a response
//   resp_listo    in   consumer takes the head this cycle
//   Respuesta     out  head zero flag
//   Racha         out  [RACHA_W-1:0] head run length
//   total_ceros   out  [15:0] accepted zero tuples (IGUALCERO_TOTAL_EN only)
// -----------------------------------------------------------------------------
module respuesta_cero_stream #(
  parameter int ANCHO   = 16,
  parameter int RACHA_W = 8
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic [ANCHO-1:0]   Tupla,
  input  logic               tupla_valida,
  output logic               tupla_listo,
  input  logic               limpiar,
  output logic               resp_valida,
  input  logic               resp_listo,
  output logic               Respuesta,
  output logic [RACHA_W-1:0] Racha
`ifdef IGUALCERO_TOTAL_EN
  ,
  output logic [15:0]        total_ceros
`endif
);

  localparam int ENT_W = RACHA_W + 1;
  localparam logic [RACHA_W-1:0] RACHA_MAX = '1;

  // Buffer is a two-stage shift FIFO: ent0 is always the head, ent1 the
  // entry behind it. ocupacion counts valid entries (0..2).
  logic [1:0]         ocupacion;
  logic [ENT_W-1:0]   ent0;
  logic [ENT_W-1:0]   ent1;
  logic [RACHA_W-1:0] racha;

  logic               acepta;
  logic               saca;
  logic               es_cero;
  logic [RACHA_W-1:0] racha_base;
  logic [RACHA_W-1:0] racha_nueva;
  logic [ENT_W-1:0]   ent_nueva;

  assign tupla_listo = (ocupacion != 2'd2);
  assign resp_valida = (ocupacion != 2'd0);
  assign acepta      = tupla_valida && tupla_listo;
  assign saca        = resp_valida && resp_listo;
  assign Respuesta   = ent0[ENT_W-1];
  assign Racha       = ent0[RACHA_W-1:0];

  // Response for the tuple on the input this cycle. limpiar is applied
  // before the increment, so a cleared zero tuple starts a new run at 1.
  always_comb begin
    es_cero     = (Tupla == '0);
    racha_base  = limpiar ? '0 : racha;
    racha_nueva = '0;
    if (es_cero) begin
      if (racha_base == RACHA_MAX) begin
        racha_nueva = RACHA_MAX;
      end else begin
        racha_nueva = racha_base + 1'b1;
      end
    end
    ent_nueva = {es_cero, racha_nueva};
  end

  // Run counter
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      racha <= '0;
    end else if (acepta) begin
      racha <= racha_nueva;
    end else if (limpiar) begin
      racha <= '0;
    end
  end

  // Response buffer
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ocupacion <= 2'd0;
      ent0      <= '0;
      ent1      <= '0;
    end else begin
      case ({acepta, saca})
        2'b10: begin
          if (ocupacion == 2'd0) begin
            ent0 <= ent_nueva;
          end else begin
            ent1 <= ent_nueva;
          end
          ocupacion <= ocupacion + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves ent0 holding the popped value.
          if (ocupacion == 2'd2) begin
            ent0 <= ent1;
          end
          ocupacion <= ocupacion - 2'd1;
        end
        2'b11: begin
          // Accept needs a free slot and pop needs an entry, so the buffer
          // holds exactly one: the new response replaces the leaving head.
          ent0 <= ent_nueva;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IGUALCERO_TOTAL_EN
  // Counted at accept time, independent of the buffer; wraps naturally.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      total_ceros <= 16'd0;
    end else if (acepta && es_cero) begin
      total_ceros <= (limpiar ? 16'd0 : total_ceros) + 16'd1;
    end else if (limpiar) begin
      total_ceros <= 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_respuesta_cero_stream.sv
// Directed bench for respuesta_cero_stream. A queue-based model of the
// response stream is advanced on every rising edge; one compare process
// checks the DUT against it on every falling edge. Responses observed
// leaving the DUT are logged so directed tests can pin literal values.
module tb_respuesta_cero_stream;

  localparam int ANCHO   = 16;
  localparam int RACHA_W = 8;
  localparam int RMAX    = (1 << RACHA_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  logic [ANCHO-1:0]   Tupla = '0;
  logic               tupla_valida = 1'b0;
  logic               tupla_listo;
  logic               limpiar = 1'b0;
  logic               resp_valida;
  logic               resp_listo = 1'b0;
  logic               Respuesta;
  logic [RACHA_W-1:0] Racha;
`ifdef IGUALCERO_TOTAL_EN
  logic [15:0]        total_ceros;
`endif

  respuesta_cero_stream #(.ANCHO(ANCHO), .RACHA_W(RACHA_W)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .Tupla        (Tupla),
    .tupla_valida (tupla_valida),
    .tupla_listo  (tupla_listo),
    .limpiar      (limpiar),
    .resp_valida  (resp_valida),
    .resp_listo   (resp_listo),
    .Respuesta    (Respuesta),
    .Racha        (Racha)
`ifdef IGUALCERO_TOTAL_EN
    ,
    .total_ceros  (total_ceros)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  logic [RACHA_W:0] exp_q[$];   // expected responses waiting in the buffer
  logic [RACHA_W:0] obs_q[$];   // responses seen leaving the DUT
  int m_racha = 0;
  int m_total = 0;
  logic m_acc, m_pop, m_zero;
  int m_nr;

  always @(negedge reset_L) begin
    exp_q.delete();
    m_racha = 0;
    m_total = 0;
  end

  always @(posedge clk) begin
    if (reset_L && started) begin
      m_acc = tupla_valida && (exp_q.size() < 2);
      m_pop = (exp_q.size() > 0) && resp_listo;
      m_zero = (Tupla == 0);
      m_nr = 0;
      if (m_acc) begin
        m_nr = limpiar ? 0 : m_racha;
        m_nr = m_zero ? ((m_nr + 1 > RMAX) ? RMAX : m_nr + 1) : 0;
        m_racha = m_nr;
        if (m_zero) m_total = ((limpiar ? 0 : m_total) + 1) % 65536;
        else if (limpiar) m_total = 0;
      end else if (limpiar) begin
        m_racha = 0;
        m_total = 0;
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_acc) exp_q.push_back({m_zero, RACHA_W'(m_nr)});
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started && reset_L) begin
      chk("tupla_listo", 32'(tupla_listo), 32'(exp_q.size() != 2));
      chk("resp_valida", 32'(resp_valida), 32'(exp_q.size() != 0));
      if (exp_q.size() > 0) begin
        chk("Respuesta", 32'(Respuesta), 32'(exp_q[0][RACHA_W]));
        chk("Racha", 32'(Racha), 32'(exp_q[0][RACHA_W-1:0]));
      end
`ifdef IGUALCERO_TOTAL_EN
      chk("total_ceros", 32'(total_ceros), 32'(m_total));
`endif
      if (resp_valida && resp_listo) obs_q.push_back({Respuesta, Racha});
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic do_reset();
    tupla_valida = 1'b0;
    limpiar = 1'b0;
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
    started = 1'b1;
    obs_q.delete();
  endtask

  task automatic send(input logic [15:0] t, input logic lim);
    int w;
    w = 0;
    tupla_valida = 1'b1;
    Tupla = t;
    limpiar = lim;
    @(negedge clk);
    while (!tupla_listo && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!tupla_listo) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: tupla_listo stayed 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    tupla_valida = 1'b0;
    limpiar = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string nm, input int idx, input logic fl, input int r);
    if (idx >= obs_q.size()) begin
      chk({nm, "_missing"}, 32'(obs_q.size()), 32'(idx + 1));
    end else begin
      chk({nm, "_flag"}, 32'(obs_q[idx][RACHA_W]), 32'(fl));
      chk({nm, "_racha"}, 32'(obs_q[idx][RACHA_W-1:0]), 32'(r));
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Reset state
    #2;
    chk("reset_resp_valida", 32'(resp_valida), 32'd0);
    chk("reset_tupla_listo", 32'(tupla_listo), 32'd1);
    chk("reset_Racha", 32'(Racha), 32'd0);
    do_reset();

    // 1: basic stream, consumer always ready
    resp_listo = 1'b1;
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h0003, 1'b0);
    send(16'h0000, 1'b0);
    idle(3);
    check_obs("t1_r0", 0, 1'b1, 1);
    check_obs("t1_r1", 1, 1'b1, 2);
    check_obs("t1_r2", 2, 1'b0, 0);
    check_obs("t1_r3", 3, 1'b1, 1);
    chk("t1_count", 32'(obs_q.size()), 32'd4);

    // 2: back-pressure fills the buffer
    do_reset();
    resp_listo = 1'b0;
    tupla_valida = 1'b1;
    Tupla = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t2_full_listo", 32'(tupla_listo), 32'd0);
    chk("t2_head_valid", 32'(resp_valida), 32'd1);
    chk("t2_head_racha", 32'(Racha), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t2_still_full", 32'(tupla_listo), 32'd0);
    chk("t2_head_stable", 32'(Racha), 32'd1);
    @(posedge clk);
    #1;
    resp_listo = 1'b1;
    send(16'h0000, 1'b0);
    idle(3);
    check_obs("t2_r0", 0, 1'b1, 1);
    check_obs("t2_r1", 1, 1'b1, 2);
    check_obs("t2_r2", 2, 1'b1, 3);

    // 3: saturation
    do_reset();
    resp_listo = 1'b1;
    for (int i = 0; i < 300; i++) send(16'h0000, 1'b0);
    send(16'h0001, 1'b0);
    idle(3);
    check_obs("t3_254th", 253, 1'b1, 254);
    check_obs("t3_255th", 254, 1'b1, 255);
    check_obs("t3_256th", 255, 1'b1, 255);
    check_obs("t3_300th", 299, 1'b1, 255);
    check_obs("t3_nonzero", 300, 1'b0, 0);

    // 4: limpiar together with an accepted zero tuple
    do_reset();
    resp_listo = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    send(16'h0000, 1'b0);
    idle(3);
    check_obs("t4_run4", 3, 1'b1, 4);
    check_obs("t4_clear", 4, 1'b1, 1);
    check_obs("t4_after", 5, 1'b1, 2);

    // 5: asynchronous reset with a full buffer
    do_reset();
    resp_listo = 1'b0;
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    chk("t5_full_before", 32'(tupla_listo), 32'd0);
    #2;
    reset_L = 1'b0;
    #1;
    chk("t5_async_valid", 32'(resp_valida), 32'd0);
    chk("t5_async_listo", 32'(tupla_listo), 32'd1);
    @(negedge clk);
    #1;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    obs_q.delete();
    resp_listo = 1'b1;
    send(16'h0000, 1'b0);
    idle(2);
    check_obs("t5_after_reset", 0, 1'b1, 1);

`ifdef IGUALCERO_TOTAL_EN
    // 6: total counter
    do_reset();
    resp_listo = 1'b1;
    send(16'h0000, 1'b0);
    send(16'h0005, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    chk("t6_total3", 32'(total_ceros), 32'd3);
    do_reset();
    resp_listo = 1'b1;
    for (int i = 0; i < 65535; i++) send(16'h0000, 1'b0);
    chk("t6_total_ffff", 32'(total_ceros), 32'h0000_FFFF);
    send(16'h0000, 1'b0);
    chk("t6_total_wrap", 32'(total_ceros), 32'd0);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/respuesta_cero_stream.md
Name: respuesta_cero_stream

Overview:
- Registered, handshaked counterpart to the combinational 16-bit zero detector.
- Consumes a stream of tuples and produces a response stream, one response per accepted tuple, in arrival order.
- Each response carries the zero flag and the length of the current run of consecutive zero tuples.
- Sits between the tuple producer and the response consumer; a 2-entry response buffer absorbs consumer back-pressure.

Parameters:
- ANCHO, 16, tuple width in bits.
- RACHA_W, 8, width of the zero-run counter; saturates at 2**RACHA_W-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- Tupla  input  ANCHO  tuple under test.
- tupla_valida  input  1  Tupla is valid this cycle.
- tupla_listo  output  1  block can accept a tuple; = (ocupacion != 2), driven from registered state only.
- limpiar  input  1  synchronous clear of run counter (and total counter, if compiled in).
- resp_valida  output  1  buffer head holds a response.
- resp_listo  input  1  consumer takes the head this cycle.
- Respuesta  output  1  head zero flag; 1 when the tuple was all zeros.
- Racha  output  RACHA_W  head run length, counting the tuple itself.

Behaviour:
- Reset (reset_L low, any time, asynchronous): ocupacion=0, racha=0, buffer entries cleared. Outputs: resp_valida=0, Respuesta=0, Racha=0, tupla_listo=1. Any in-flight responses are discarded.
- Accept condition: tupla_valida && tupla_listo.
- On accept, computed in the same cycle:
  - es_cero = (Tupla == 0).
  - racha_nueva = es_cero ? min(racha+1, 2**RACHA_W-1) : 0.
  - {es_cero, racha_nueva} is pushed at the buffer tail.
  - The racha register takes racha_nueva.
- No accept: racha holds its value.
- limpiar=1 without accept: racha=0 next cycle.
- limpiar=1 with accept: clear takes effect first. racha_nueva = es_cero ? 1 : 0, and that value is pushed.
- Buffer: 2-entry FIFO.
  - ocupacion in {0,1,2}.
  - Push on accept; pop on resp_valida && resp_listo.
  - Push and pop in the same cycle leave ocupacion unchanged, with order preserved.
- Latency: a tuple accepted in cycle N appears at the head in cycle N+1 when the buffer was empty. Otherwise it appears after all earlier responses.
- Full (ocupacion=2): tupla_listo=0 and input is ignored. A pop in that cycle frees a slot; tupla_listo rises the next cycle. There is no combinational ready path from resp_listo to tupla_listo.
- Empty: resp_valida=0. Respuesta/Racha hold the last-popped values but are don't-care. The bench must check them only while resp_valida=1.
- resp_listo with resp_valida=0: no effect.
- Head outputs are stable while resp_valida=1 && resp_listo=0.
- Saturation: Racha sticks at 2**RACHA_W-1 (255 by default) for further zero tuples and never wraps. A nonzero tuple returns it to 0.

Optional Feature:
- Macro: IGUALCERO_TOTAL_EN.
- Defined:
  - Adds output port total_ceros (16 bits), reset to 0.
  - Increments by 1 on each accepted zero tuple and wraps 0xFFFF -> 0x0000.
  - Cleared by limpiar; limpiar with an accepted zero tuple gives total_ceros=1.
  - Counts at accept time, independent of the buffer.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then tuples 0x0000,0x0000,0x0003,0x0000 with resp_listo=1 -> responses (1,1),(1,2),(0,0),(1,1), each one cycle after its accept.
- resp_listo=0, offer 0x0000 for 3 cycles -> 2 accepted; tupla_listo=0 from the cycle after the 2nd accept. Raise resp_listo -> (1,1),(1,2) popped in order, then the 3rd tuple is accepted yielding (1,3).
- 300 consecutive 0x0000 with RACHA_W=8 -> Racha reaches 255 at the 255th and stays 255 through the 300th. Then 0x0001 -> (0,0).
- Zero run to Racha=4, then limpiar=1 with 0x0000 accepted in the same cycle -> response (1,1). Next 0x0000 -> (1,2).
- Assert reset_L low mid-stream with ocupacion=2 -> resp_valida=0 and tupla_listo=1 immediately (before the next clk edge). After release, 0x0000 -> (1,1).
- With IGUALCERO_TOTAL_EN: tuples 0,5,0,0 -> total_ceros=3. Preload 0xFFFF zeros then one more -> 0x0000.
